div_seq: RTL and testbench



---
 rtl/div_seq.sv | 104 ++++++++++
 tb/tb_div_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Multicycle signed divider for MIPS DIV: restoring algorithm, one quotient bit per cycle.
// state | meaning
// IDLE  | waiting for start; operand magnitudes and signs latched on start
// CALC  | WIDTH shift/subtract iterations on the unsigned magnitudes
// FIX   | apply signs, load hi_out/lo_out, pulse done
// ZERO  | divisor was zero; pulse div_zero, results untouched
module div_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             div_zero,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, ZERO} stateT;

  stateT            state, nextState;
  logic [WIDTH-1:0] divisor, rem, quo;
  logic [CW-1:0]    iterCnt;
  logic             signQ, signR;
  logic [WIDTH-1:0] absA, absB, remShift;
  logic [WIDTH:0]   trial;
  logic             bZero, lastIter;

  // Unsigned negate: the magnitude of the most negative value is itself, read as unsigned.
  assign absA     = a_in[WIDTH-1] ? (~a_in + 1'b1) : a_in;
  assign absB     = b_in[WIDTH-1] ? (~b_in + 1'b1) : b_in;
  assign bZero    = (b_in == '0);
  assign lastIter = (iterCnt == LAST_ITER);

  // rem < divisor <= 2^(WIDTH-1), so the shifted remainder always fits in WIDTH bits.
  assign remShift = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial    = {1'b0, remShift} - {1'b0, divisor};

  always_comb begin
    nextState = state;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (start) nextState = bZero ? ZERO : CALC;
      CALC: if (lastIter) nextState = FIX;
      FIX:  nextState = IDLE;
      ZERO: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      divisor  <= '0;
      rem      <= '0;
      quo      <= '0;
      iterCnt  <= '0;
      signQ    <= 1'b0;
      signR    <= 1'b0;
      hi_out   <= '0;
      lo_out   <= '0;
      div_zero <= 1'b0;
      done     <= 1'b0;
    end else begin
      div_zero <= 1'b0;
      done     <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !bZero) begin
            divisor <= absB;
            quo     <= absA;
            rem     <= '0;
            iterCnt <= '0;
            signQ   <= a_in[WIDTH-1] ^ b_in[WIDTH-1];
            signR   <= a_in[WIDTH-1];
          end
        end
        CALC: begin
          rem     <= trial[WIDTH] ? remShift : trial[WIDTH-1:0];
          quo     <= {quo[WIDTH-2:0], ~trial[WIDTH]};
          iterCnt <= iterCnt + 1'b1;
        end
        FIX: begin
          lo_out <= signQ ? (~quo + 1'b1) : quo;
          hi_out <= signR ? (~rem + 1'b1) : rem;
          done   <= 1'b1;
        end
        ZERO: div_zero <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Randomized and directed bench for div_seq against a plain signed-arithmetic model.
module tb_div_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] aIn, bIn;
  logic [31:0] hiOut, loOut;
  logic        divZero, busy, done;

  int checks = 0;
  int errors = 0;

  localparam int DONE_EDGE = 33;  // edges after the start-sampling edge: 34th cycle counting the start cycle
  localparam int WINDOW    = 40;

  div_seq #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .a_in(aIn), .b_in(bIn),
    .hi_out(hiOut), .lo_out(loOut), .div_zero(divZero), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Launch one operation and observe a fixed window; optionally inject a second start mid-run.
  task automatic runDiv(input logic [31:0] a, input logic [31:0] b,
                        input int injEdge, input logic [31:0] ia, input logic [31:0] ib,
                        output int doneEdge, output int doneCnt, output int busyCnt,
                        output int zeroEdge, output int zeroCnt,
                        output logic [31:0] hi, output logic [31:0] lo);
    doneEdge = -1; doneCnt = 0; busyCnt = 0; zeroEdge = -1; zeroCnt = 0;
    @(negedge clk);
    aIn = a; bIn = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e <= WINDOW; e++) begin
      if (e > 0) begin
        if (e == injEdge) begin aIn = ia; bIn = ib; start = 1'b1; end
        @(posedge clk); #1;
        start = 1'b0;
      end
      if (busy) busyCnt++;
      if (done) begin doneCnt++; if (doneEdge < 0) doneEdge = e; end
      if (divZero) begin zeroCnt++; if (zeroEdge < 0) zeroEdge = e; end
    end
    hi = hiOut; lo = loOut;
  endtask

  function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] q, output logic [31:0] r);
    longint sa, sb, lq, lr;
    logic [63:0] tq, tr;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    lq = sa / sb;
    lr = sa % sb;
    tq = lq; tr = lr;
    q = tq[31:0];
    r = tr[31:0];
  endfunction

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; aIn = 32'd9; bIn = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (hiOut !== 32'd0) begin errors++; $display("FAIL reset_hi got %h want 0", hiOut); end
    checks++; if (loOut !== 32'd0) begin errors++; $display("FAIL reset_lo got %h want 0", loOut); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0 || divZero !== 1'b0) begin
      errors++; $display("FAIL reset_pulses got done=%b div_zero=%b want 0 0", done, divZero); end
    start = 1'b0; reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_start_ignored got busy=%b want 0", busy); end
  endtask

  task automatic test_directed();
    int de, dc, bc, ze, zc; logic [31:0] hi, lo;
    runDiv(32'd7, 32'd2, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (de !== DONE_EDGE) begin errors++; $display("FAIL pos_latency got %0d want %0d", de, DONE_EDGE); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL pos_busy_cycles got %0d want 33", bc); end
    checks++; if (dc !== 1) begin errors++; $display("FAIL pos_done_pulses got %0d want 1", dc); end
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin
      errors++; $display("FAIL pos_7_2 got lo=%h hi=%h want 3 1", lo, hi); end
    runDiv(32'hFFFF_FFF9, 32'd2, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      errors++; $display("FAIL neg_dividend got lo=%h hi=%h want fffffffd ffffffff", lo, hi); end
    runDiv(32'd7, 32'hFFFF_FFFE, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'hFFFF_FFFD || hi !== 32'd1) begin
      errors++; $display("FAIL neg_divisor got lo=%h hi=%h want fffffffd 1", lo, hi); end
  endtask

  task automatic test_div_zero();
    int de, dc, bc, ze, zc; logic [31:0] hi, lo;
    runDiv(32'd7, 32'd2, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    runDiv(32'd5, 32'd0, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (ze !== 1) begin errors++; $display("FAIL zero_edge got %0d want 1", ze); end
    checks++; if (zc !== 1) begin errors++; $display("FAIL zero_pulse_len got %0d want 1", zc); end
    checks++; if (dc !== 0) begin errors++; $display("FAIL zero_no_done got %0d want 0", dc); end
    checks++; if (lo !== 32'd3 || hi !== 32'd1) begin
      errors++; $display("FAIL zero_hold got lo=%h hi=%h want 3 1", lo, hi); end
  endtask

  task automatic test_overflow();
    int de, dc, bc, ze, zc; logic [31:0] hi, lo;
    runDiv(32'h8000_0000, 32'hFFFF_FFFF, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0 || zc !== 0) begin
      errors++; $display("FAIL ovf_min_neg1 got lo=%h hi=%h zero=%0d want 80000000 0 0", lo, hi, zc); end
    runDiv(32'h8000_0000, 32'd1, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      errors++; $display("FAIL min_div_1 got lo=%h hi=%h want 80000000 0", lo, hi); end
  endtask

  task automatic test_reset_mid();
    int de, dc, bc, ze, zc, seenDone; logic [31:0] hi, lo;
    @(negedge clk);
    aIn = 32'd100; bIn = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (hiOut !== 32'd0 || loOut !== 32'd0) begin
      errors++; $display("FAIL midreset_results got lo=%h hi=%h want 0 0", loOut, hiOut); end
    checks++; if (busy !== 1'b0 || done !== 1'b0 || divZero !== 1'b0) begin
      errors++; $display("FAIL midreset_flags got busy=%b done=%b dz=%b want 0 0 0", busy, done, divZero); end
    seenDone = 0;
    for (int e = 0; e < WINDOW; e++) begin
      @(posedge clk); #1;
      if (done) seenDone++;
    end
    checks++; if (seenDone !== 0) begin errors++; $display("FAIL midreset_no_done got %0d want 0", seenDone); end
    runDiv(32'd100, 32'd7, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'd14 || hi !== 32'd2 || de !== DONE_EDGE) begin
      errors++; $display("FAIL midreset_fresh got lo=%h hi=%h edge=%0d want e 2 %0d", lo, hi, de, DONE_EDGE); end
  endtask

  task automatic test_start_busy();
    int de, dc, bc, ze, zc; logic [31:0] hi, lo;
    runDiv(32'd9, 32'd3, 5, 32'd1, 32'd1, de, dc, bc, ze, zc, hi, lo);
    checks++; if (lo !== 32'd3 || hi !== 32'd0) begin
      errors++; $display("FAIL busy_start got lo=%h hi=%h want 3 0", lo, hi); end
    checks++; if (de !== DONE_EDGE || dc !== 1) begin
      errors++; $display("FAIL busy_start_done got edge=%0d pulses=%0d want %0d 1", de, dc, DONE_EDGE); end
  endtask

  task automatic test_random();
    int de, dc, bc, ze, zc; logic [31:0] hi, lo, a, b, expQ, expR, lastHi, lastLo;
    lastHi = hiOut; lastLo = loOut;
    for (int n = 0; n < 40; n++) begin
      a = $urandom;
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(0, 1) ? 32'($urandom_range(1, 15)) : -32'($urandom_range(1, 15));
        4:       a = 32'h8000_0000 ^ 32'($urandom_range(0, 3));
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      if (n > 0 && b == 32'd0 && $urandom_range(0, 3) != 0) b = 32'd11;
      runDiv(a, b, -1, 0, 0, de, dc, bc, ze, zc, hi, lo);
      if (b == 32'd0) begin
        checks++; if (zc !== 1 || dc !== 0 || hi !== lastHi || lo !== lastLo) begin
          errors++; $display("FAIL rand_zero a=%h got dz=%0d done=%0d lo=%h hi=%h want 1 0 %h %h",
                             a, zc, dc, lo, hi, lastLo, lastHi); end
      end else begin
        model(a, b, expQ, expR);
        checks++; if (lo !== expQ || hi !== expR || de !== DONE_EDGE || zc !== 0) begin
          errors++; $display("FAIL rand_div a=%h b=%h got lo=%h hi=%h edge=%0d dz=%0d want %h %h %0d 0",
                             a, b, lo, hi, de, zc, expQ, expR, DONE_EDGE); end
        lastHi = expR; lastLo = expQ;
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; aIn = '0; bIn = '0;
    test_reset();
    test_directed();
    test_div_zero();
    test_overflow();
    test_reset_mid();
    test_start_busy();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
